cf_fft_pingpong_reorder: RTL and testbench

- Parametrised ping-pong frame buffer placed between FFT stages. Successor to the fixed 256x32 stage buffer.
- One bank accepts random-address writes from the upstream stage while the other bank is read out sequentially.
- Readout is in natural or bit-reversed order, selected at runtime.
- Adds frame-valid tracking and a write-collision error flag.

---
 rtl/cf_fft_pkg.sv | 24 ++
 rtl/cf_fft_bank_toggle.sv | 18 +
 rtl/cf_fft_pingpong_reorder.sv | 92 +++++++++
 tb/tb_cf_fft_pingpong_reorder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cf_fft_pkg.sv
// Shared constants, read-mode enum and bit-reverse helper for the FFT stage buffers.
package cf_fft_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_LOG2N = 8;
  localparam int MAX_LOG2N = 16;

  typedef enum logic {
    MODE_NATURAL = 1'b0,
    MODE_BITREV  = 1'b1
  } rd_mode_e;

  // Reverses the low 'width' bits of v; bits at and above 'width' come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                  input int width);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cf_fft_bank_toggle.sv
// Ping-pong bank select: flips on every accepted frame start.
module cf_fft_bank_toggle (
  input  logic clock_c,
  input  logic reset,
  input  logic ce,
  input  logic start,
  output logic bank
);

  always_ff @(posedge clock_c) begin
    if (reset) begin
      bank <= 1'b0;
    end else if (ce && start) begin
      bank <= ~bank;
    end
  end

endmodule

// File: rtl/cf_fft_pingpong_reorder.sv
// Ping-pong frame buffer: random-address writes into one bank, natural or
// bit-reversed sequential readout of the other.
module cf_fft_pingpong_reorder
  import cf_fft_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic             clock_c,
  input  logic             reset,
  input  logic             ce,
  input  logic             start,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             bit_rev,
  output logic             o_start,
  output logic             o_first,
  output logic             o_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_bank,
  output logic             o_err
);

  localparam int N = 1 << LOG2N;

  logic [DW-1:0]    mem0 [N];
  logic [DW-1:0]    mem1 [N];

  logic [LOG2N-1:0] rd_cnt;
  logic [LOG2N-1:0] rd_cnt_nxt;
  logic [LOG2N-1:0] raddr;
  logic [LOG2N-1:0] raddr_nxt;
  logic             rsel;
  logic             rsel_nxt;
  rd_mode_e         mode_q;
  rd_mode_e         mode_nxt;

  cf_fft_bank_toggle u_bank_toggle (
    .clock_c (clock_c),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .bank    (o_bank)
  );

  // The address register is loaded from the counter's next value, so the word
  // selected by counter value k appears on o_data in the same cycle that the
  // counter shows k; o_start, o_first and word 0 therefore line up.
  always_comb begin
    rd_cnt_nxt = start ? '0 : rd_cnt + 1'b1;
    mode_nxt   = start ? rd_mode_e'(bit_rev) : mode_q;
    raddr_nxt  = rd_cnt_nxt;
    if (mode_nxt == MODE_BITREV) begin
      raddr_nxt = LOG2N'(bitrev(MAX_LOG2N'(rd_cnt_nxt), LOG2N));
    end
    // Read bank is the complement of the write bank as it stands after any toggle.
    rsel_nxt = start ? o_bank : ~o_bank;
  end

  always_ff @(posedge clock_c) begin
    if (reset) begin
      rd_cnt  <= '0;
      raddr   <= '0;
      rsel    <= 1'b1;
      mode_q  <= MODE_NATURAL;
      o_start <= 1'b0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else if (ce) begin
      rd_cnt  <= rd_cnt_nxt;
      raddr   <= raddr_nxt;
      rsel    <= rsel_nxt;
      mode_q  <= mode_nxt;
      o_start <= start;
      if (start) o_valid <= 1'b1;
      if (start && wr_en) o_err <= 1'b1;
    end
  end

  // A write coinciding with start still targets the pre-toggle bank (frame tail).
  always_ff @(posedge clock_c) begin
    if (!reset && ce && wr_en) begin
      if (o_bank) mem1[wr_addr] <= wr_data;
      else        mem0[wr_addr] <= wr_data;
    end
  end

  assign o_first = (rd_cnt == '0);
  assign o_data  = rsel ? mem1[raddr] : mem0[raddr];

endmodule

// File: tb/tb_cf_fft_pingpong_reorder.sv
// Directed bench for the ping-pong reorder buffer at LOG2N=3, DW=16.
module tb_cf_fft_pingpong_reorder;

  localparam int DW    = 16;
  localparam int LOG2N = 3;

  // clock / reset
  logic             clock_c = 1'b0;
  logic             reset   = 1'b1;
  logic             ce      = 1'b1;
  logic             start   = 1'b0;
  logic             wr_en   = 1'b0;
  logic [LOG2N-1:0] wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             bit_rev = 1'b0;
  logic             o_start;
  logic             o_first;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_bank;
  logic             o_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock_c = ~clock_c;

  cf_fft_pingpong_reorder #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clock_c (clock_c),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .bit_rev (bit_rev),
    .o_start (o_start),
    .o_first (o_first),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_bank  (o_bank),
    .o_err   (o_err)
  );

  // driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clock_c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int a = 0; a < 8; a++) begin
      wr_en   = 1'b1;
      wr_addr = LOG2N'(a);
      wr_data = base + DW'(a);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic br);
    start   = 1'b1;
    bit_rev = br;
    step();
    start   = 1'b0;
  endtask

  logic [DW-1:0] brev_seq [8];

  initial begin
    brev_seq = '{16'h100, 16'h104, 16'h102, 16'h106, 16'h101, 16'h105, 16'h103, 16'h107};

    // reset state
    step();
    step();
    chk("rst_first", 32'(o_first), 32'd1);
    chk("rst_start", 32'(o_start), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_bank",  32'(o_bank),  32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    reset = 1'b0;

    // natural readout of bank 0
    fill(16'h100);
    chk("nat_valid_pre", 32'(o_valid), 32'd0);
    do_start(1'b0);
    chk("nat_ostart", 32'(o_start), 32'd1);
    chk("nat_first",  32'(o_first), 32'd1);
    chk("nat_valid",  32'(o_valid), 32'd1);
    chk("nat_bank",   32'(o_bank),  32'd1);
    chk("nat_d0",     32'(o_data),  32'h100);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("nat_d",     32'(o_data),  32'h100 + 32'(i));
      chk("nat_first", 32'(o_first), 32'd0);
    end
    chk("nat_ostart_low", 32'(o_start), 32'd0);

    // bit-reversed readout of bank 1; bit_rev flips mid-frame with no effect
    fill(16'h100);
    do_start(1'b1);
    chk("br_bank", 32'(o_bank), 32'd0);
    chk("br_d0",   32'(o_data), 32'(brev_seq[0]));
    for (int i = 1; i < 8; i++) begin
      if (i == 4) bit_rev = 1'b0;
      step();
      chk("br_d", 32'(o_data), 32'(brev_seq[i]));
    end

    // ping-pong isolation: frame B written while frame A reads out
    fill(16'h0A0);
    do_start(1'b0);
    chk("pp_bank_a", 32'(o_bank), 32'd1);
    chk("pp_a0",     32'(o_data), 32'h0A0);
    for (int a = 0; a < 8; a++) begin
      wr_en   = 1'b1;
      wr_addr = LOG2N'(a);
      wr_data = 16'h0B0 + DW'(a);
      step();
      chk("pp_a", 32'(o_data), 32'h0A0 + 32'((a + 1) % 8));
    end
    wr_en = 1'b0;
    do_start(1'b0);
    chk("pp_bank_b", 32'(o_bank), 32'd0);
    chk("pp_b0",     32'(o_data), 32'h0B0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("pp_b", 32'(o_data), 32'h0B0 + 32'(i));
    end

    // ce gating mid-readout
    fill(16'h0C0);
    do_start(1'b0);
    step();
    step();
    chk("ce_pre", 32'(o_data), 32'h0C2);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ce_hold_d",     32'(o_data),  32'h0C2);
      chk("ce_hold_first", 32'(o_first), 32'd0);
      chk("ce_hold_bank",  32'(o_bank),  32'd1);
    end
    ce = 1'b1;
    for (int i = 3; i < 8; i++) begin
      step();
      chk("ce_resume", 32'(o_data), 32'h0C0 + 32'(i));
    end
    step();
    chk("ce_wrap_first", 32'(o_first), 32'd1);

    // collision: last word written together with start lands in the old bank
    for (int a = 0; a < 7; a++) begin
      wr_en   = 1'b1;
      wr_addr = LOG2N'(a);
      wr_data = 16'h0D0 + DW'(a);
      step();
    end
    chk("col_err_pre", 32'(o_err), 32'd0);
    wr_addr = 3'd7;
    wr_data = 16'h0D7;
    do_start(1'b0);
    wr_en = 1'b0;
    chk("col_err",  32'(o_err),  32'd1);
    chk("col_bank", 32'(o_bank), 32'd0);
    chk("col_d0",   32'(o_data), 32'h0D0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("col_d", 32'(o_data), 32'h0D0 + 32'(i));
    end
    // wrap: 10 ce-cycles without start
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("wrap_d",     32'(o_data),  32'h0D0 + 32'((7 + k) % 8));
      chk("wrap_first", 32'(o_first), 32'(((7 + k) % 8) == 0));
    end
    chk("col_err_sticky", 32'(o_err), 32'd1);

    // reset mid-frame at word 4
    do_start(1'b0);
    chk("mr_bank", 32'(o_bank), 32'd1);
    for (int i = 1; i <= 4; i++) step();
    chk("mr_d4",    32'(o_data),  32'h0C4);
    chk("mr_first", 32'(o_first), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_bank0", 32'(o_bank),  32'd0);
    chk("mr_first1",32'(o_first), 32'd1);
    chk("mr_err",   32'(o_err),   32'd0);
    chk("mr_start", 32'(o_start), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
